// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants, state type and error codes for the instruction memory loader
package imem_pkg;

    localparam int MEM_BYTES = 128;
    localparam int IMEM_AW   = 7;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } loader_state_t;

    // Reserved for a future status register; the loader currently only exposes err.
    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - length-prefixed byte stream to instruction memory writer (optional IMEM_LOADER_CSUM_EN)
module imem_loader
    import imem_pkg::*;
#(
    parameter int MEM_BYTES = imem_pkg::MEM_BYTES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [IMEM_AW-1:0] w_addr_imem,
    output logic [7:0]         w_data_imem,
    output logic               w_en_imem,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               core_rst_n
);

    localparam int         AW      = $clog2(MEM_BYTES);
    localparam logic [8:0] MAX_LEN = 9'(MEM_BYTES);

    loader_state_t      state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [7:0]         len_q, len_d;
    logic               w_en_q, w_en_d;
    logic [IMEM_AW-1:0] w_addr_q, w_addr_d;
    logic [7:0]         w_data_q, w_data_d;
    logic               released_q, released_d;
    logic               core_rst_n_q, core_rst_n_d;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]         sum_q, sum_d;
`endif

    logic accept;
    logic busy_c;

    assign busy_c   = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign in_ready = busy_c;
    assign accept   = in_valid && busy_c;

    // Next-state, write-port and core-reset computation
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        w_en_d     = 1'b0;
        w_addr_d   = w_addr_q;
        w_data_d   = w_data_q;
`ifdef IMEM_LOADER_CSUM_EN
        sum_d      = sum_q;
`endif
        // The core stays held until a load has completed cleanly at least once.
        released_d   = released_q || (state_q == S_DONE);
        core_rst_n_d = !busy_c && (released_q || (state_q == S_DONE));

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN;
                    cnt_d   = 8'd0;
`ifdef IMEM_LOADER_CSUM_EN
                    sum_d   = 8'd0;
`endif
                end
            end
            S_LEN: begin
                if (accept) begin
                    if ((in_data == 8'd0) || ({1'b0, in_data} > MAX_LEN)) begin
                        state_d = S_ERR;
                    end else begin
                        len_d   = in_data;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    w_en_d   = 1'b1;
                    w_addr_d = cnt_q[AW-1:0];
                    w_data_d = in_data;
                    cnt_d    = cnt_q + 8'd1;
`ifdef IMEM_LOADER_CSUM_EN
                    sum_d    = sum_q + in_data;
                    if (cnt_q + 8'd1 == len_q) state_d = S_CSUM;
`else
                    if (cnt_q + 8'd1 == len_q) state_d = S_DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CSUM_EN
            S_CSUM: begin
                if (accept) begin
                    state_d = (in_data == sum_q) ? S_DONE : S_ERR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset abandons any session and holds the core
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            len_q        <= 8'd0;
            w_en_q       <= 1'b0;
            w_addr_q     <= '0;
            w_data_q     <= 8'd0;
            released_q   <= 1'b0;
            core_rst_n_q <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
            sum_q        <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            w_en_q       <= w_en_d;
            w_addr_q     <= w_addr_d;
            w_data_q     <= w_data_d;
            released_q   <= released_d;
            core_rst_n_q <= core_rst_n_d;
`ifdef IMEM_LOADER_CSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign w_en_imem   = w_en_q;
    assign w_addr_imem = w_addr_q;
    assign w_data_imem = w_data_q;
    assign busy        = busy_c;
    assign done        = (state_q == S_DONE);
    assign err         = (state_q == S_ERR);
    assign core_rst_n  = core_rst_n_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - table-driven and sequence checks for imem_loader
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [6:0] w_addr_imem;
    logic [7:0] w_data_imem;
    logic       w_en_imem;
    logic       busy;
    logic       done;
    logic       err;
    logic       core_rst_n;

    int checks = 0;
    int errors = 0;
    bit released_m = 1'b0;

    logic [6:0] addr_log[$];
    logic [7:0] data_log[$];

    imem_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .w_addr_imem (w_addr_imem),
        .w_data_imem (w_data_imem),
        .w_en_imem   (w_en_imem),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .core_rst_n  (core_rst_n)
    );

    always #5 clk = ~clk;

    // Log every memory write strobe, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n && w_en_imem) begin
            addr_log.push_back(w_addr_imem);
            data_log.push_back(w_data_imem);
        end
    end

    typedef struct {
        string       name;
        logic [7:0]  len;
        int          n_data;
        logic [31:0] data;
        logic [7:0]  csum;
        bit          good_len;
        bit          done_c;
        bit          done_nc;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        k = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL send_byte_timeout: in_ready stayed 0 for byte 0x%0h", b);
        end
        @(posedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Checks common to every session end: flags at the first cycle after the last accept,
    // core reset one cycle later.
    task automatic finish_session(input string name, input bit exp_done);
        @(negedge clk);
        in_valid = 1'b0;
        check({name, "_done"}, done, exp_done);
        check({name, "_err"}, err, !exp_done);
        check({name, "_busy"}, busy, 0);
        check({name, "_core_held"}, core_rst_n, 0);
        if (exp_done) released_m = 1'b1;
        @(negedge clk);
        check({name, "_core_after"}, core_rst_n, released_m);
    endtask

    task automatic check_writes(input string name, input int base, input int n, input logic [31:0] data);
        int bad;
        bad = 0;
        check({name, "_nwrites"}, addr_log.size() - base, n);
        for (int i = 0; i < n && base + i < addr_log.size(); i++) begin
            if (addr_log[base + i] != 7'(i) || data_log[base + i] != data[8*i +: 8]) bad++;
        end
        check({name, "_write_content"}, bad, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int  base;
        bit  exp_done;
        base = addr_log.size();
`ifdef IMEM_LOADER_CSUM_EN
        exp_done = v.done_c;
`else
        exp_done = v.done_nc;
`endif
        pulse_start();
        send_byte(v.len);
        for (int i = 0; i < v.n_data; i++) send_byte(v.data[8*i +: 8]);
`ifdef IMEM_LOADER_CSUM_EN
        if (v.good_len) send_byte(v.csum);
`endif
        finish_session(v.name, exp_done);
        check_writes(v.name, base, v.n_data, v.data);
    endtask

    initial begin
        int base;
        int bad;

        vecs[0] = '{"l4",     8'd4,   4, 32'h0000_0013, 8'h13, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{"len0",   8'd0,   0, 32'h0,         8'h00, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{"len200", 8'd200, 0, 32'h0,         8'h00, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{"aa55",   8'd2,   2, 32'h0000_55AA, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{"l3",     8'd3,   3, 32'h0003_0201, 8'h06, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{"l1",     8'd1,   1, 32'h0000_00FF, 8'hFF, 1'b1, 1'b1, 1'b1};

        #2;
        check("rst_ready", in_ready, 0);
        check("rst_wen", w_en_imem, 0);
        check("rst_waddr", w_addr_imem, 0);
        check("rst_wdata", w_data_imem, 0);
        check("rst_flags", {busy, done, err}, 3'b000);
        check("rst_core", core_rst_n, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_core_held", core_rst_n, 0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Full-size load 0x00..0x7F
        base = addr_log.size();
        pulse_start();
        send_byte(8'd128);
        for (int i = 0; i < 128; i++) send_byte(8'(i));
`ifdef IMEM_LOADER_CSUM_EN
        send_byte(8'hC0);
`endif
        finish_session("l128", 1'b1);
        check("l128_nwrites", addr_log.size() - base, 128);
        bad = 0;
        for (int i = 0; i < 128 && base + i < addr_log.size(); i++)
            if (addr_log[base + i] != 7'(i) || data_log[base + i] != 8'(i)) bad++;
        check("l128_content", bad, 0);
        check("l128_last_addr", addr_log[addr_log.size() - 1], 7'h7F);

        // start together with in_valid in DONE, then gapped data with ignored start pulses
        base = addr_log.size();
        @(negedge clk);
        start = 1'b1; in_valid = 1'b1; in_data = 8'd3;
        @(negedge clk);
        start = 1'b0;
        check("sv_busy", busy, 1);
        check("sv_no_write", addr_log.size() - base, 0);
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("gap_still_busy", busy, 1);
            in_data = 8'h21 + 8'(i);
            in_valid = 1'b1;
            @(posedge clk);
        end
`ifdef IMEM_LOADER_CSUM_EN
        send_byte(8'h66);
`endif
        finish_session("gap", 1'b1);
        check_writes("gap", base, 3, 32'h0023_2221);

        // Reset after the third data byte
        base = addr_log.size();
        pulse_start();
        send_byte(8'd5);
        send_byte(8'h41);
        send_byte(8'h42);
        send_byte(8'h43);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        released_m = 1'b0;
        #1;
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_wen", w_en_imem, 0);
        check("mid_rst_waddr", w_addr_imem, 0);
        check("mid_rst_wdata", w_data_imem, 0);
        check("mid_rst_flags", {busy, done, err}, 3'b000);
        check("mid_rst_core", core_rst_n, 0);
        check_writes("mid_rst", base, 3, 32'h0043_4241);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(vecs[4]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Write-side companion to the instruction memory: accepts a length-prefixed byte stream over a valid/ready handshake and writes it byte-by-byte into the 128-byte instruction memory, starting at address 0. It keeps the core in reset while a load is in progress. It reports completion, or error on a bad length or checksum. It sits between the host byte link (UART receiver or testbench driver) and the memory's write port.

## Interface
Parameters:
- MEM_BYTES, 128, instruction memory size in bytes; address width is clog2(MEM_BYTES) = 7

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins a load session when not busy
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader can accept a byte this cycle
- w_addr_imem  out  7  memory byte write address
- w_data_imem  out  8  memory byte write data
- w_en_imem  out  1  memory byte write strobe, one cycle per byte
- busy  out  1  session in progress
- done  out  1  sticky: last session completed cleanly
- err  out  1  sticky: last session failed
- core_rst_n  out  1  active-low reset to the core; low while busy

## Operation
- States: IDLE, LEN, DATA, CSUM, DONE, ERR.
- Stream format: length byte L, then L data bytes, then one checksum byte. The checksum byte is present only when CSUM is enabled; see Configuration.
- IDLE/DONE/ERR + start → LEN. On entry, clear the byte counter, clear the running sum, clear done and err.
- start is ignored in LEN/DATA/CSUM.
- LEN, on accept:
  - L == 0 or L > MEM_BYTES → ERR.
  - Otherwise latch L → DATA.
- DATA, on accept:
  - Write byte at address = counter.
  - Add the byte to the running 8-bit sum (mod 256).
  - Increment the counter.
  - After the L-th byte → CSUM (or DONE when CSUM is disabled).
- CSUM, on accept:
  - Byte == running sum → DONE.
  - Byte != running sum → ERR.
- Bytes already written before an error stay in memory; no rollback.
- Accept = in_valid && in_ready in the same cycle.
- in_ready = 1 exactly in LEN, DATA and CSUM. It is combinational from state only, never from in_valid.
- busy = state ∈ {LEN, DATA, CSUM}.
- core_rst_n = !busy, registered, so the core releases one cycle after leaving busy.
- done = state == DONE.
- err = state == ERR.
- Counter is 8 bits wide, so it can hold MEM_BYTES. Address = counter[6:0]; it never wraps because L ≤ 128.

## Timing
- Reset values:
  - State IDLE.
  - in_ready 0, w_en_imem 0, w_addr_imem 0, w_data_imem 0.
  - busy 0, done 0, err 0.
  - core_rst_n 0: the core is held until the first successful load or an explicit release. Leaving IDLE via reset only does not release it.
  - core_rst_n rises one cycle after the first transition into DONE.
  - core_rst_n stays high in ERR only if it was already high; otherwise it remains 0.
- Write latency: a byte accepted in cycle N produces a registered w_en_imem, w_addr_imem and w_data_imem in cycle N+1. w_en_imem is high for exactly one cycle.
- Throughput: one byte per cycle when in_valid is held high.
- Transition on the final accept takes effect next cycle. done/err are asserted from the cycle after the final byte is accepted.
- start and in_valid in the same cycle while in IDLE: start takes effect and the byte is not accepted, because in_ready = 0 in IDLE.
- Reset mid-session: return to IDLE immediately and hold the core in reset. Bytes written so far remain valid in memory.

## Configuration
- IMEM_LOADER_CSUM_EN defined:
  - The CSUM state and the running-sum register exist.
  - The stream carries a trailing checksum byte.
  - A mismatch → ERR.
- Not defined:
  - No CSUM state and no sum register.
  - The L-th data byte → DONE directly.
  - err is raised only for a bad length.

## Structure
- Shared package `imem_pkg`:
  - MEM_BYTES constant and IMEM_AW = 7.
  - State enum type `loader_state_t`.
  - Error-code localparams, for future status readout.
- No sub-module needed. The checksum accumulator stays inline.

## Test plan
- Reset → start, send L=4, bytes 13 00 00 00, csum 0x13 → four writes to addresses 0..3 with the given data, done=1, core_rst_n rises one cycle after DONE.
- Send L=128 with bytes 0x00..0x7F and the correct csum 0xC0 → 128 writes, last at address 0x7F, done=1, no address wrap.
- L=0, then separately L=200 → err=1, no w_en_imem pulses.
- L=2, bytes AA 55, csum 0x00 (expected 0xFF) → two writes, then err=1. Without the macro, the same stream minus csum → done=1.
- in_valid toggled every other cycle during DATA → writes only on accepted cycles, addresses contiguous.
- rst_n asserted after the 3rd data byte → all outputs return to reset values; a fresh start reloads correctly.
